// File: rtl/frogger_game_fsm_if.sv
// Game-control bundle between the frog motion/collision blocks and the game FSM.
// master drives frog state and player requests; slave is the FSM.
interface frogger_game_fsm_if #(
   parameter int NUM_FROGS = 3,
   parameter int NUM_HOMES = 3,
   parameter int LIFE_W    = 2
);
   logic                   start_game;
   logic                   pause;
   logic [NUM_FROGS*11-1:0] frog_x;
   logic [NUM_FROGS*11-1:0] frog_y;
   logic                   dead_frog;
   logic [LIFE_W-1:0]      frog_lives;
   logic [NUM_HOMES-1:0]   homes_filled;
   logic [6:0]             time_left;
   logic                   respawn;
   logic                   win_game;
   logic                   lose_game;
   logic [2:0]             game_state;

   modport master (
      output start_game, pause, frog_x, frog_y, dead_frog,
      input  frog_lives, homes_filled, time_left, respawn, win_game, lose_game, game_state
   );

   modport slave (
      input  start_game, pause, frog_x, frog_y, dead_frog,
      output frog_lives, homes_filled, time_left, respawn, win_game, lose_game, game_state
   );
endinterface

// File: rtl/frogger_game_fsm.sv
// Frame-rate game controller: lives, home slots, per-life countdown and
// the death/respawn sequence, with win/lose flags for the overlay.
module frogger_home_slot #(
   parameter int          NUM_FROGS = 3,
   parameter logic [10:0] HOME_Y    = 11'd40,
   parameter logic [10:0] SLOT_X    = 11'd120
) (
   input  logic [NUM_FROGS*11-1:0] frog_x_i,
   input  logic [NUM_FROGS*11-1:0] frog_y_i,
   output logic                    hit_o
);
   // Any frog on the slot sets it; several frogs on one slot still give one hit.
   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < NUM_FROGS; i++)
         if (frog_y_i[11*i +: 11] == HOME_Y && frog_x_i[11*i +: 11] == SLOT_X)
            hit_o = 1'b1;
   end
endmodule

module frogger_game_fsm #(
   parameter int                       NUM_FROGS      = 3,
   parameter int                       NUM_HOMES      = 3,
   parameter logic [10:0]              HOME_Y         = 11'd40,
   parameter logic [NUM_HOMES*11-1:0]  HOME_X         = {11'd480, 11'd280, 11'd120},
   parameter int                       LIVES          = 3,
   parameter int                       LIFE_W         = 2,
   parameter int                       ROUND_SECONDS  = 60,
   parameter int                       FRAMES_PER_SEC = 60,
   parameter int                       DEATH_FRAMES   = 30
) (
   input  logic                frame_clk,
   input  logic                game_restart,
   frogger_game_fsm_if.slave   gif
);
   localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam int DC_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_DYING = 3'd2,
      S_WIN   = 3'd3,
      S_LOSE  = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [LIFE_W-1:0]     lives_q, lives_d;
   logic [NUM_HOMES-1:0]  homes_q, homes_d;
   logic [6:0]            time_q, time_d;
   logic [FC_W-1:0]       fcnt_q, fcnt_d;
   logic [DC_W-1:0]       dcnt_q, dcnt_d;
   logic                  respawn_q, respawn_d;
   logic                  win_q, win_d;
   logic                  lose_q, lose_d;

   logic [NUM_HOMES-1:0]  hits;
   logic [NUM_HOMES-1:0]  homes_next;
   logic                  frame_wrap, timeout, enter_play, full_init;

   for (genvar k = 0; k < NUM_HOMES; k++) begin : g_slot
      frogger_home_slot #(
         .NUM_FROGS (NUM_FROGS),
         .HOME_Y    (HOME_Y),
         .SLOT_X    (HOME_X[11*k +: 11])
      ) u_slot (
         .frog_x_i (gif.frog_x),
         .frog_y_i (gif.frog_y),
         .hit_o    (hits[k])
      );
   end

   assign homes_next = homes_q | hits;
   assign frame_wrap = (fcnt_q == FC_W'(FRAMES_PER_SEC - 1));
   assign timeout    = frame_wrap && (time_q == 7'd1);

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      homes_d    = homes_q;
      time_d     = time_q;
      fcnt_d     = fcnt_q;
      dcnt_d     = dcnt_q;
      respawn_d  = 1'b0;
      enter_play = 1'b0;
      full_init  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (gif.start_game) begin
               enter_play = 1'b1;
               full_init  = 1'b1;
            end
         end
         S_PLAY: begin
            if (!gif.pause) begin
               homes_d = homes_next;
               // Win is checked before death so a last-home landing always counts.
               if (&homes_next) begin
                  state_d = S_WIN;
               end else if (gif.dead_frog || timeout) begin
                  if (timeout) begin
                     time_d = 7'd0;
                     fcnt_d = '0;
                  end
                  if (lives_q == LIFE_W'(1)) begin
                     lives_d = '0;
                     state_d = S_LOSE;
                  end else begin
                     lives_d = lives_q - LIFE_W'(1);
                     dcnt_d  = '0;
                     state_d = S_DYING;
                  end
               end else if (frame_wrap) begin
                  fcnt_d = '0;
                  if (time_q != 7'd0)
                     time_d = time_q - 7'd1;
               end else begin
                  fcnt_d = fcnt_q + FC_W'(1);
               end
            end
         end
         S_DYING: begin
            if (dcnt_q == DC_W'(DEATH_FRAMES - 1))
               enter_play = 1'b1;
            else
               dcnt_d = dcnt_q + DC_W'(1);
         end
         S_WIN, S_LOSE: begin
            if (gif.start_game) begin
               enter_play = 1'b1;
               full_init  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_play) begin
         state_d   = S_PLAY;
         respawn_d = 1'b1;
         time_d    = 7'(ROUND_SECONDS);
         fcnt_d    = '0;
      end
      if (full_init) begin
         lives_d = LIFE_W'(LIVES);
         homes_d = '0;
      end

      win_d  = (state_d == S_WIN);
      lose_d = (state_d == S_LOSE);
   end

   always_ff @(posedge frame_clk or posedge game_restart) begin
      if (game_restart) begin
         state_q   <= S_IDLE;
         lives_q   <= LIFE_W'(LIVES);
         homes_q   <= '0;
         time_q    <= 7'(ROUND_SECONDS);
         fcnt_q    <= '0;
         dcnt_q    <= '0;
         respawn_q <= 1'b0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         homes_q   <= homes_d;
         time_q    <= time_d;
         fcnt_q    <= fcnt_d;
         dcnt_q    <= dcnt_d;
         respawn_q <= respawn_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
      end
   end

   assign gif.frog_lives   = lives_q;
   assign gif.homes_filled = homes_q;
   assign gif.time_left    = time_q;
   assign gif.respawn      = respawn_q;
   assign gif.win_game     = win_q;
   assign gif.lose_game    = lose_q;
   assign gif.game_state   = state_q;
endmodule

// File: tb/tb_frogger_game_fsm.sv
// Directed bench for frogger_game_fsm: homes, deaths, timer, win/lose and reset.
module tb_frogger_game_fsm;
   logic frame_clk = 1'b0;
   logic game_restart;
   int   n_chk  = 0;
   int   n_fail = 0;

   frogger_game_fsm_if #(.NUM_FROGS(3), .NUM_HOMES(3), .LIFE_W(2)) gif ();

   frogger_game_fsm dut (
      .frame_clk    (frame_clk),
      .game_restart (game_restart),
      .gif          (gif)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_frog(input int i, input logic [10:0] x, input logic [10:0] y);
      gif.frog_x[11*i +: 11] = x;
      gif.frog_y[11*i +: 11] = y;
   endtask

   task automatic clear_frogs();
      gif.frog_x = '0;
      gif.frog_y = '0;
   endtask

   task automatic pulse_start();
      gif.start_game = 1'b1;
      tick();
      gif.start_game = 1'b0;
   endtask

   task automatic pulse_dead();
      gif.dead_frog = 1'b1;
      tick();
      gif.dead_frog = 1'b0;
   endtask

   initial begin
      game_restart   = 1'b1;
      gif.start_game = 1'b0;
      gif.pause      = 1'b0;
      gif.dead_frog  = 1'b0;
      clear_frogs();
      #3;
      chk("rst_state", gif.game_state, 0);
      chk("rst_lives", gif.frog_lives, 3);
      chk("rst_homes", gif.homes_filled, 0);
      chk("rst_time",  gif.time_left, 60);
      chk("rst_flags", {gif.respawn, gif.win_game, gif.lose_game}, 0);
      ticks(2);
      game_restart = 1'b0;
      tick();
      chk("idle_hold", gif.game_state, 0);

      // start from IDLE
      pulse_start();
      chk("start_state",   gif.game_state, 1);
      chk("start_respawn", gif.respawn, 1);
      chk("start_lives",   gif.frog_lives, 3);
      chk("start_time",    gif.time_left, 60);
      tick();
      chk("respawn_1cyc",  gif.respawn, 0);
      pulse_start();
      chk("start_in_play_resp",  gif.respawn, 0);
      chk("start_in_play_state", gif.game_state, 1);

      // homes fill 001 -> 011 -> 111, duplicate frogs on one slot
      set_frog(0, 11'd120, 11'd40); tick();
      chk("home_001", gif.homes_filled, 3'b001);
      clear_frogs(); tick();
      chk("home_sticky", gif.homes_filled, 3'b001);
      set_frog(0, 11'd120, 11'd41); tick();
      chk("home_wrong_y", gif.homes_filled, 3'b001);
      clear_frogs();
      set_frog(1, 11'd280, 11'd40); set_frog(2, 11'd280, 11'd40); tick();
      chk("home_011", gif.homes_filled, 3'b011);
      chk("home_011_state", gif.game_state, 1);
      clear_frogs();
      set_frog(2, 11'd480, 11'd40); tick();
      chk("home_111", gif.homes_filled, 3'b111);
      chk("win_state", gif.game_state, 3);
      chk("win_flag",  gif.win_game, 1);
      clear_frogs(); ticks(3);
      chk("win_hold", gif.win_game, 1);

      // replay from WIN
      pulse_start();
      chk("replay_state", gif.game_state, 1);
      chk("replay_resp",  gif.respawn, 1);
      chk("replay_homes", gif.homes_filled, 0);
      chk("replay_lives", gif.frog_lives, 3);
      chk("replay_win",   gif.win_game, 0);

      // death 1: inputs ignored while DYING
      pulse_dead();
      chk("d1_state", gif.game_state, 2);
      chk("d1_lives", gif.frog_lives, 2);
      gif.dead_frog = 1'b1;
      set_frog(0, 11'd120, 11'd40);
      ticks(5);
      gif.dead_frog = 1'b0;
      clear_frogs();
      ticks(24);
      chk("d1_dying29", gif.game_state, 2);
      chk("d1_lives_hold", gif.frog_lives, 2);
      chk("d1_homes_hold", gif.homes_filled, 0);
      chk("d1_no_resp", gif.respawn, 0);
      tick();
      chk("d1_play",  gif.game_state, 1);
      chk("d1_resp",  gif.respawn, 1);
      chk("d1_time",  gif.time_left, 60);

      // death 2
      pulse_dead();
      chk("d2_lives", gif.frog_lives, 1);
      ticks(30);
      chk("d2_play", gif.game_state, 1);
      chk("d2_resp", gif.respawn, 1);

      // death 3 -> LOSE
      pulse_dead();
      chk("d3_state", gif.game_state, 4);
      chk("d3_lives", gif.frog_lives, 0);
      chk("d3_lose",  gif.lose_game, 1);
      chk("d3_resp",  gif.respawn, 0);

      // replay from LOSE, then timer run with pause
      pulse_start();
      chk("lose_replay_lives", gif.frog_lives, 3);
      chk("lose_replay_flag",  gif.lose_game, 0);
      ticks(1800);
      chk("tmr_half", gif.time_left, 30);
      gif.pause = 1'b1;
      ticks(50);
      gif.dead_frog = 1'b1; tick(); gif.dead_frog = 1'b0;
      ticks(49);
      chk("pause_time",  gif.time_left, 30);
      chk("pause_lives", gif.frog_lives, 3);
      chk("pause_state", gif.game_state, 1);
      gif.pause = 1'b0;
      ticks(1799);
      chk("tmr_last_sec", gif.time_left, 1);
      chk("tmr_last_lives", gif.frog_lives, 3);
      pulse_dead();
      chk("tmo_time",  gif.time_left, 0);
      chk("tmo_lives", gif.frog_lives, 2);
      chk("tmo_state", gif.game_state, 2);
      ticks(30);
      chk("tmo_reload", gif.time_left, 60);

      // down to one life, then last home with same-cycle death
      pulse_dead();
      chk("w1_lives", gif.frog_lives, 1);
      ticks(30);
      set_frog(0, 11'd120, 11'd40); tick();
      clear_frogs(); set_frog(1, 11'd280, 11'd40); tick();
      chk("w1_homes", gif.homes_filled, 3'b011);
      clear_frogs(); set_frog(2, 11'd480, 11'd40);
      pulse_dead();
      chk("w1_state", gif.game_state, 3);
      chk("w1_lives", gif.frog_lives, 1);
      chk("w1_win",   gif.win_game, 1);
      chk("w1_lose",  gif.lose_game, 0);
      clear_frogs();

      // async restart while DYING
      pulse_start();
      chk("w1_replay_lives", gif.frog_lives, 3);
      chk("w1_replay_homes", gif.homes_filled, 0);
      pulse_dead();
      ticks(4);
      chk("ar_dying", gif.game_state, 2);
      #2 game_restart = 1'b1;
      #1;
      chk("ar_state", gif.game_state, 0);
      chk("ar_lives", gif.frog_lives, 3);
      chk("ar_time",  gif.time_left, 60);
      chk("ar_flags", {gif.respawn, gif.win_game, gif.lose_game}, 0);
      tick();
      game_restart = 1'b0;
      tick();
      chk("ar_idle", gif.game_state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
